instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Purpose : instruction fetch stage with program memory, PC sequencing,
//           beq/bne branch resolution and an IDLE/RUN/HALT controller.
// Latency : zero-cycle combinational fetch (instr follows pc in the same
//           cycle); pc, state and retired update on the rising clk edge.
// Backpressure: none. The stage advances one instruction per cycle in RUN.
//           Program loads are accepted only in IDLE or HALT.
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   load_en/addr/data   program-load write port (ignored while running)
//   start               one-cycle pulse: (re)start execution at RESET_PC
//   branch, zero        control-unit Branch signal and ALU zero flag
//   instr, opcode       current instruction word and its [31:26] field
//   pc, pc_plus4        current program counter and pc + 4
//   running, halted     state flags (RUN / HALT)
//   retired             instructions executed since last reset or start
module instr_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFC00_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    input  logic                          branch,
    input  logic                          zero,
    output logic [31:0]                   instr,
    output logic [5:0]                    opcode,
    output logic [31:0]                   pc,
    output logic [31:0]                   pc_plus4,
    output logic                          running,
    output logic                          halted,
    output logic [31:0]                   retired
);

    localparam int AW = $clog2(IMEM_DEPTH);

    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_BNE = 6'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_retired;

    // Program memory. Deliberately has no reset so a loaded program
    // survives rst and can be re-run with another start pulse.
    logic [31:0] r_imem [IMEM_DEPTH];

    // ------------------------------------------------------------------
    // Combinational fetch and branch resolution
    // ------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_retired_nxt;

    logic        w_in_range;
    logic [31:0] w_imem_rd;
    logic [31:0] w_instr;
    logic [5:0]  w_opcode;
    logic        w_is_halt;
    logic        w_taken;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_retired_inc;
    logic        w_load_we;

    // pc is inside memory when every bit above the word-address field is
    // zero, i.e. pc < 4*IMEM_DEPTH. pc[1:0] never takes part in the read.
    assign w_in_range = (r_pc[31:AW+2] == '0);
    assign w_imem_rd  = r_imem[r_pc[AW+1:2]];

    // Anything that is not an in-range fetch in RUN reads as the halt
    // word, so running off the end of memory stops the machine cleanly.
    assign w_instr   = ((r_state == S_RUN) && w_in_range) ? w_imem_rd : HALT_WORD;
    assign w_opcode  = w_instr[31:26];
    assign w_is_halt = (w_instr == HALT_WORD);

    // Branch is only honoured for beq/bne; a stray Branch on any other
    // opcode falls through to sequential fetch.
    assign w_taken = branch && (((w_opcode == OP_BEQ) &&  zero) ||
                                ((w_opcode == OP_BNE) && !zero));

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_offset = {{14{w_instr[15]}}, w_instr[15:0], 2'b00};
    assign w_br_target = w_pc_plus4 + w_br_offset;

    // Saturating count: holds at all-ones rather than wrapping to zero.
    assign w_retired_inc = (r_retired == 32'hFFFF_FFFF) ? r_retired
                                                        : r_retired + 32'd1;

    // Reset wins over a coincident load; RUN ignores loads entirely.
    assign w_load_we = load_en && !rst && (r_state != S_RUN);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_retired_nxt = r_retired;

        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_state_nxt   = S_RUN;
                    w_pc_nxt      = RESET_PC;
                    w_retired_nxt = 32'd0;
                end
            end

            S_RUN: begin
                // start is ignored here: a running program is never
                // restarted underneath itself.
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_pc_nxt      = w_taken ? w_br_target : w_pc_plus4;
                    w_retired_nxt = w_retired_inc;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_retired <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    // Write happens on the same edge that may also take IDLE->RUN, so a
    // load coinciding with start is visible to the very first fetch.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_imem[load_addr] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr    = w_instr;
    assign opcode   = w_opcode;
    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign running  = (r_state == S_RUN);
    assign halted   = (r_state == S_HALT);
    assign retired  = r_retired;

endmodule
